// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART block: arbiter,
//               transmitter and receiver state encodings, requester count
//               and a one-hot helper for requester acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Number of requesters sharing one transmitter.
    localparam int NUM_REQ = 4;

    // Arbiter state encoding.
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LAUNCH      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACTIVE = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE   = 3'd3;
    localparam logic [2:0] ST_GAP         = 3'd4;

    typedef enum logic [2:0] {
        ARB_IDLE        = ST_IDLE,
        ARB_LAUNCH      = ST_LAUNCH,
        ARB_WAIT_ACTIVE = ST_WAIT_ACTIVE,
        ARB_WAIT_DONE   = ST_WAIT_DONE,
        ARB_GAP         = ST_GAP
    } arb_state_t;

    // Transmitter state encoding.
    localparam logic [2:0] TX_ST_IDLE      = 3'd0;
    localparam logic [2:0] TX_ST_START_BIT = 3'd1;
    localparam logic [2:0] TX_ST_DATA_BITS = 3'd2;
    localparam logic [2:0] TX_ST_STOP_BIT  = 3'd3;
    localparam logic [2:0] TX_ST_CLEANUP   = 3'd4;

    // Receiver state encoding.
    localparam logic [2:0] RX_ST_IDLE      = 3'd0;
    localparam logic [2:0] RX_ST_START_BIT = 3'd1;
    localparam logic [2:0] RX_ST_DATA_BITS = 3'd2;
    localparam logic [2:0] RX_ST_STOP_BIT  = 3'd3;
    localparam logic [2:0] RX_ST_CLEANUP   = 3'd4;

    // One-hot acknowledge vector for a requester index.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
        req_onehot      = '0;
        req_onehot[idx] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick4
// Description : Combinational round-robin pick among four requesters.
//               The search starts at the requester after i_Ptr and wraps,
//               so i_Ptr itself has the lowest priority.
// Ports       : i_Req   - request vector, one bit per requester
//               i_Ptr   - index of the most recent winner
//               o_Idx   - index of the selected requester (0 when none)
//               o_Valid - at least one request is present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick4
    import uart_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [1:0]         i_Ptr,
    output logic [1:0]         o_Idx,
    output logic               o_Valid
);

    logic [1:0] w_cand;

    // Walk candidates from farthest (ptr+4 == ptr) down to nearest (ptr+1);
    // the last hit written wins, so ptr+1 gets the highest priority.
    always_comb begin
        o_Idx   = 2'd0;
        o_Valid = 1'b0;
        w_cand  = 2'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = i_Ptr + 2'(k);
            if (i_Req[w_cand]) begin
                o_Idx   = w_cand;
                o_Valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART transmitter among four
//               byte requesters. A winner's byte is latched in IDLE, launched
//               for one cycle, then the arbiter follows the transmitter's
//               active/done status with a timeout guard before re-arbitrating.
// Ports       : i_Clock     - clock, rising edge
//               i_Rst_L     - asynchronous active-low reset
//               i_Req_DV    - per-requester byte valid
//               i_Req_Byte  - requester k byte on [8k+7:8k]
//               o_Req_Ack   - one-cycle acknowledge to the winning requester
//               o_Tx_DV     - one-cycle launch pulse to the transmitter
//               o_Tx_Byte   - byte presented to the transmitter
//               i_Tx_Active - transmitter busy status
//               i_Tx_Done   - transmitter completion status
//               o_Grant_Id  - current or last granted requester
//               o_Busy      - arbiter is not idle
//               o_Timeout   - one-cycle pulse when a transfer is abandoned
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic [NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [1:0]           o_Grant_Id,
    output logic                 o_Busy,
    output logic                 o_Timeout
);

    import uart_pkg::*;

    localparam int                 c_CNT_W    = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CLKS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    arb_state_t           state_q;
    logic [1:0]           rr_ptr_q;
    logic [c_CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 tx_dv_q;
    logic [7:0]           tx_byte_q;
    logic [1:0]           grant_q;
    logic                 busy_q;
    logic                 timeout_q;

    logic [1:0]           w_pick_idx;
    logic                 w_pick_valid;
    logic [7:0]           w_pick_byte;
    logic [c_CNT_W-1:0]   w_cnt_inc;

    rr_pick4 u_pick (
        .i_Req   (i_Req_DV),
        .i_Ptr   (rr_ptr_q),
        .o_Idx   (w_pick_idx),
        .o_Valid (w_pick_valid)
    );

    assign w_pick_byte = i_Req_Byte[{w_pick_idx, 3'b000} +: 8];
    assign w_cnt_inc   = cnt_q + c_CNT_ONE;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= 2'd3;
            cnt_q     <= '0;
            ack_q     <= '0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
            grant_q   <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Pulse outputs default low; only state transitions raise them.
            ack_q     <= '0;
            tx_dv_q   <= 1'b0;
            timeout_q <= 1'b0;

            case (state_q)
                ARB_IDLE: begin
                    // A done status still high must not overlap a new launch.
                    if (w_pick_valid && !i_Tx_Done) begin
                        tx_byte_q <= w_pick_byte;
                        grant_q   <= w_pick_idx;
                        rr_ptr_q  <= w_pick_idx;
                        ack_q     <= req_onehot(w_pick_idx);
                        tx_dv_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ARB_LAUNCH;
                    end
                end

                ARB_LAUNCH: begin
                    cnt_q   <= '0;
                    state_q <= ARB_WAIT_ACTIVE;
                end

                ARB_WAIT_ACTIVE: begin
                    // The counter stops at its last value because the
                    // machine leaves the waiting states when it gets there.
                    cnt_q <= w_cnt_inc;
                    if (w_cnt_inc == c_CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ARB_GAP;
                    end else if (i_Tx_Active) begin
                        state_q <= ARB_WAIT_DONE;
                    end
                end

                ARB_WAIT_DONE: begin
                    cnt_q <= w_cnt_inc;
                    if (w_cnt_inc == c_CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ARB_GAP;
                    end else if (i_Tx_Done) begin
                        state_q <= ARB_GAP;
                    end
                end

                ARB_GAP: begin
                    // Waiting for both status lines low absorbs a done
                    // level that lingers for more than one cycle.
                    if (!i_Tx_Done && !i_Tx_Active) begin
                        busy_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_Req_Ack  = ack_q;
    assign o_Tx_DV    = tx_dv_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Grant_Id = grant_q;
    assign o_Busy     = busy_q;
    assign o_Timeout  = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter. One instance drives a
//               behavioural transmitter (4 clocks per bit) whose serial line
//               is decoded by a behavioural receiver; a second instance with
//               a short timeout has its transmitter status tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Main instance signals
    logic [3:0]  req_dv;
    logic [31:0] req_byte;
    logic [3:0]  ack;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_active;
    logic        tx_done;
    logic [1:0]  gid;
    logic        busy;
    logic        tmo;

    // Timeout instance signals
    logic [3:0]  dv_t;
    logic [31:0] byte_t;
    logic [3:0]  ack_t;
    logic        tx_dv_t;
    logic [7:0]  tx_byte_t;
    logic        active_t;
    logic        done_t;
    logic [1:0]  gid_t;
    logic        busy_t;
    logic        tmo_t;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLKS(4096)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(req_dv), .i_Req_Byte(req_byte),
        .o_Req_Ack(ack), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Grant_Id(gid),
        .o_Busy(busy), .o_Timeout(tmo)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLKS(16)) dut_t (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Req_DV(dv_t), .i_Req_Byte(byte_t),
        .o_Req_Ack(ack_t), .o_Tx_DV(tx_dv_t), .o_Tx_Byte(tx_byte_t),
        .i_Tx_Active(active_t), .i_Tx_Done(done_t), .o_Grant_Id(gid_t),
        .o_Busy(busy_t), .o_Timeout(tmo_t)
    );

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural transmitter, 4 clocks per bit ----------
    logic [9:0]  frame;
    int          tick_cnt;
    logic        txm_busy;
    int          done_left;
    int          done_len;
    logic        tx_line;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txm_busy  <= 1'b0;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            tx_line   <= 1'b1;
            done_left <= 0;
            tick_cnt  <= 0;
            frame     <= '1;
        end else if (txm_busy) begin
            if (tick_cnt == 39) begin
                txm_busy  <= 1'b0;
                tx_active <= 1'b0;
                tx_line   <= 1'b1;
                tx_done   <= 1'b1;
                done_left <= done_len - 1;
            end else begin
                tick_cnt <= tick_cnt + 1;
                tx_line  <= frame[(tick_cnt + 1) / 4];
            end
        end else begin
            if (done_left > 0) begin
                done_left <= done_left - 1;
                tx_done   <= 1'b1;
            end else begin
                tx_done <= 1'b0;
            end
            if (tx_dv) begin
                frame     <= {1'b1, tx_byte, 1'b0};
                txm_busy  <= 1'b1;
                tx_active <= 1'b1;
                tick_cnt  <= 0;
                tx_line   <= 1'b0;
            end
        end
    end

    // ---------------- behavioural receiver on the serial line -------------
    logic        rx_busy;
    int          rx_cnt;
    logic [7:0]  rx_sh;
    logic [7:0]  rx_q[$];
    int          rx_frame_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_busy <= 1'b0;
            rx_cnt  <= 0;
            rx_q.delete();
        end else if (!rx_busy) begin
            if (!tx_line) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 5 && rx_cnt <= 33 && ((rx_cnt - 5) % 4) == 0)
                rx_sh <= {tx_line, rx_sh[7:1]};
            if (rx_cnt == 37) begin
                rx_busy <= 1'b0;
                if (tx_line) rx_q.push_back(rx_sh);
                else         rx_frame_err++;
            end
        end
    end

    // ---------------- event monitors ----------------
    int   ack_cnt = 0;
    int   dv_cnt = 0;
    int   multi_ack = 0;
    int   dv_on_done = 0;
    int   tmo_cnt_t = 0;
    logic done_d1 = 1'b0;

    always @(posedge clk) begin
        if (ack != 4'b0) ack_cnt++;
        if ($countones(ack) > 1 || $countones(ack_t) > 1) multi_ack++;
        if (tx_dv) dv_cnt++;
        if (tx_dv && done_d1) dv_on_done++;
        if (tmo_t) tmo_cnt_t++;
        done_d1 <= tx_done;
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp_ack,
                            input logic [7:0] exp_byte, input logic [1:0] exp_gid);
        int n = 0;
        while (ack === 4'b0 && n < 200) begin
            tick(1);
            n++;
        end
        chk({tag, "_ack"},  ack,     exp_ack);
        chk({tag, "_dv"},   tx_dv,   1);
        chk({tag, "_byte"}, tx_byte, exp_byte);
        chk({tag, "_gid"},  gid,     exp_gid);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            tick(1);
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    task automatic chk_rx(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        obs = 32'hDEAD_BEEF;
        if (rx_q.size() > 0) obs = {24'h0, rx_q.pop_front()};
        chk(tag, obs, {24'h0, exp});
    endtask

    int a0;
    int l0;

    initial begin
        rst_n    = 1'b0;
        req_dv   = 4'b0;
        req_byte = 32'h0;
        dv_t     = 4'b0;
        byte_t   = 32'h0;
        active_t = 1'b0;
        done_t   = 1'b0;
        done_len = 1;

        // Reset values
        #1;
        chk("rst_busy",   busy,    0);
        chk("rst_txdv",   tx_dv,   0);
        chk("rst_ack",    ack,     0);
        chk("rst_byte",   tx_byte, 0);
        chk("rst_gid",    gid,     0);
        chk("rst_tmo",    tmo,     0);
        chk("rst_busy_t", busy_t,  0);
        tick(2);
        rst_n = 1'b1;

        // Simultaneous requests: order 0,1,2,3
        a0 = ack_cnt; l0 = dv_cnt;
        req_byte = 32'h13121110;
        req_dv   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack("sim", 4'(1 << i), 8'(8'h10 + i), 2'(i));
            tick(1);
            req_dv[i] = 1'b0;
        end
        wait_idle("sim");
        for (int i = 0; i < 4; i++) chk_rx("sim_rx", 8'(8'h10 + i));
        chk("sim_ack_cnt",    ack_cnt - a0, 4);
        chk("sim_launch_cnt", dv_cnt - l0,  4);

        // Single request from requester 2
        req_byte = 32'h00A50000;
        req_dv   = 4'b0100;
        tick(1);
        chk("single_latency", ack, 4'b0100);
        wait_ack("single", 4'b0100, 8'hA5, 2'd2);
        tick(1);
        chk("single_ack_clr", ack,   0);
        chk("single_dv_clr",  tx_dv, 0);
        chk("single_busy",    busy,  1);
        req_dv = 4'b0;
        wait_idle("single");
        chk_rx("single_rx", 8'hA5);
        chk("single_byte_hold", tx_byte, 8'hA5);
        chk("single_gid_hold",  gid,     2);

        // Fairness: requester 1 continuous, requester 3 once
        req_byte = 32'h00005100;
        req_dv   = 4'b0010;
        wait_ack("fair1", 4'b0010, 8'h51, 2'd1);
        tick(1);
        req_dv   = 4'b0000;
        tick(1);
        req_byte = 32'h73005200;
        req_dv   = 4'b1010;
        wait_ack("fair3", 4'b1000, 8'h73, 2'd3);
        tick(1);
        req_dv   = 4'b0010;
        wait_ack("fair1b", 4'b0010, 8'h52, 2'd1);
        tick(1);
        req_dv   = 4'b0000;
        wait_idle("fair");
        chk_rx("fair_rx0", 8'h51);
        chk_rx("fair_rx1", 8'h73);
        chk_rx("fair_rx2", 8'h52);

        // Done held two cycles; requester 1 waiting through the gap
        done_len = 2;
        a0 = ack_cnt; l0 = dv_cnt;
        req_byte = 32'h0000C33C;
        req_dv   = 4'b0001;
        wait_ack("dw0", 4'b0001, 8'h3C, 2'd0);
        tick(1);
        req_dv   = 4'b0010;
        wait_ack("dw1", 4'b0010, 8'hC3, 2'd1);
        tick(1);
        req_dv   = 4'b0000;
        wait_idle("dw");
        chk_rx("dw_rx0", 8'h3C);
        chk_rx("dw_rx1", 8'hC3);
        chk("dw_ack_cnt",    ack_cnt - a0, 2);
        chk("dw_launch_cnt", dv_cnt - l0,  2);
        chk("dw_no_launch_on_done", dv_on_done, 0);
        done_len = 1;

        // Timeout instance: status tied low, timeout at 16 cycles after launch
        byte_t = 32'h00000099;
        dv_t   = 4'b0001;
        tick(1);
        chk("to_ack",  ack_t,     4'b0001);
        chk("to_dv",   tx_dv_t,   1);
        chk("to_byte", tx_byte_t, 8'h99);
        tick(1);
        dv_t = 4'b0;
        tick(14);
        chk("to_early",   tmo_t,  0);
        tick(1);
        chk("to_pulse",   tmo_t,  1);
        chk("to_busy_gap", busy_t, 1);
        tick(1);
        chk("to_pulse_end", tmo_t,  0);
        chk("to_idle",      busy_t, 0);
        byte_t = 32'h00007700;
        dv_t   = 4'b0010;
        tick(1);
        chk("to_next_ack",  ack_t,     4'b0010);
        chk("to_next_byte", tx_byte_t, 8'h77);
        chk("to_next_gid",  gid_t,     2'd1);
        tick(1);
        dv_t = 4'b0;
        tick(30);
        chk("to_pulse_cnt", tmo_cnt_t, 2);
        chk("to_idle2",     busy_t,    0);
        chk("main_no_tmo",  tmo,       0);

        // Reset during WAIT_DONE on the main instance
        req_byte = 32'h000000E7;
        req_dv   = 4'b0001;
        wait_ack("rstm", 4'b0001, 8'hE7, 2'd0);
        tick(1);
        req_dv = 4'b0;
        begin
            int n = 0;
            while (tx_active !== 1'b1 && n < 100) begin
                tick(1);
                n++;
            end
        end
        chk("rstm_active", tx_active, 1);
        tick(10);
        chk("rstm_busy_pre", busy, 1);
        a0 = ack_cnt;
        rst_n = 1'b0;
        #2;
        chk("rstm_busy",  busy,    0);
        chk("rstm_byte",  tx_byte, 0);
        chk("rstm_gid",   gid,     0);
        chk("rstm_ack",   ack,     0);
        chk("rstm_txdv",  tx_dv,   0);
        chk("rstm_tmo",   tmo,     0);
        req_byte = 32'h00030201;
        req_dv   = 4'b0111;
        tick(2);
        chk("rstm_no_ack_in_rst", ack_cnt - a0, 0);
        rst_n = 1'b1;
        tick(1);
        chk("rstm_first_ack", ack, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            wait_ack("rstr", 4'(1 << i), 8'(8'h01 + i), 2'(i));
            tick(1);
            req_dv[i] = 1'b0;
        end
        wait_idle("rstr");
        chk_rx("rstr_rx0", 8'h01);
        chk_rx("rstr_rx1", 8'h02);
        chk_rx("rstr_rx2", 8'h03);

        chk("onehot_acks",  multi_ack,    0);
        chk("frame_errors", rx_frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
